// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional WAIT_DONE watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        start_tx,
    input  logic                        tx_done,
    input  logic                        cts_n,
    output logic                        timeout_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  start_tx_q, start_tx_d;
    logic                  timeout_err_q, timeout_err_d;

    logic                  win_found_s;
    logic [ID_W-1:0]       win_id_s;
    logic [NUM_REQ-1:0]    win_oh_s;
    logic [DATA_W-1:0]     win_data_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]      timer_q, timer_d;
`endif

    // Round-robin search: first set req bit above the last grant, wrapping.
    always_comb begin : p_search
        int idx;
        win_found_s = 1'b0;
        win_id_s    = grant_id_q;
        win_oh_s    = {NUM_REQ{1'b0}};
        win_data_s  = {DATA_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(grant_id_q) + k) % NUM_REQ;
            if (!win_found_s && req[idx]) begin
                win_found_s   = 1'b1;
                win_id_s      = ID_W'(idx);
                win_oh_s[idx] = 1'b1;
                win_data_s    = req_data[idx*DATA_W +: DATA_W];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_d       = state_q;
        gnt_d         = {NUM_REQ{1'b0}};
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        tx_data_d     = tx_data_q;
        start_tx_d    = 1'b0;
        timeout_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timer_d       = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (!cts_n && win_found_s) begin
                    gnt_d      = win_oh_s;
                    grant_id_d = win_id_s;
                    tx_data_d  = win_data_s;
                    start_tx_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    timer_d    = {TMR_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                // cts_n is deliberately not looked at here: a frame in flight always completes.
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`else
                end else begin
                    state_d = WAIT_DONE;
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            gnt_q         <= {NUM_REQ{1'b0}};
            grant_id_q    <= ID_W'(NUM_REQ - 1);
            busy_q        <= 1'b0;
            tx_data_q     <= {DATA_W{1'b0}};
            start_tx_q    <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timer_q       <= {TMR_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            tx_data_q     <= tx_data_d;
            start_tx_q    <= start_tx_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign tx_data     = tx_data_q;
    assign start_tx    = start_tx_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  tx_data;
    logic        start_tx;
    logic        tx_done;
    logic        cts_n;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .grant_id(grant_id),
        .busy(busy),
        .tx_data(tx_data),
        .start_tx(start_tx),
        .tx_done(tx_done),
        .cts_n(cts_n),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_start(input int max_c, input string nm, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (start_tx !== 1'b1 && c < max_c);
        n_vec++;
        if (start_tx !== 1'b1) begin
            $display("FAIL %s: start_tx=%b after %0d cycles, required 1", nm, start_tx, c);
            n_err++;
        end
    endtask

    task automatic test_reset();
        req = 4'b0000; req_data = 32'h0; tx_done = 1'b0; cts_n = 1'b0;
        do_reset();
        n_vec++;
        if ({gnt, start_tx, busy, tx_data, timeout_err, grant_id} !== {4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3}) begin
            $display("FAIL reset: gnt=%b start=%b busy=%b data=%h terr=%b gid=%0d, required 0000 0 0 00 0 3",
                     gnt, start_tx, busy, tx_data, timeout_err, grant_id);
            n_err++;
        end
    endtask

    task automatic test_single();
        req = 4'b0001; req_data = 32'h0000_00A5; cts_n = 1'b0;
        step();
        n_vec++;
        if ({gnt, start_tx, tx_data, busy} !== {4'b0001, 1'b1, 8'hA5, 1'b1}) begin
            $display("FAIL single_grant: gnt=%b start=%b data=%h busy=%b, required 0001 1 a5 1",
                     gnt, start_tx, tx_data, busy);
            n_err++;
        end
        req = 4'b0000;
        step();
        n_vec++;
        if ({gnt, start_tx, busy} !== {4'b0000, 1'b0, 1'b1}) begin
            $display("FAIL single_pulse: gnt=%b start=%b busy=%b, required 0000 0 1", gnt, start_tx, busy);
            n_err++;
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL single_done: busy=%b, required 0", busy);
            n_err++;
        end
    endtask

    task automatic test_rotation();
        int c;
        int exp_id;
        do_reset();
        req = 4'b1111; req_data = 32'h1312_1110;
        wait_start(10, "rot_first_start", c);
        for (int i = 0; i < 5; i++) begin
            exp_id = i % 4;
            n_vec++;
            if (gnt !== (4'b0001 << exp_id) || tx_data !== (8'h10 + 8'(exp_id))) begin
                $display("FAIL rot_order[%0d]: gnt=%b data=%h, required %b %h",
                         i, gnt, tx_data, 4'b0001 << exp_id, 8'h10 + 8'(exp_id));
                n_err++;
            end
            step();
            n_vec++;
            if (start_tx !== 1'b0) begin
                $display("FAIL rot_pulse[%0d]: start_tx=%b, required 0", i, start_tx);
                n_err++;
            end
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            n_vec++;
            if (busy !== 1'b0) begin
                $display("FAIL rot_done[%0d]: busy=%b, required 0", i, busy);
                n_err++;
            end
            if (i < 4) begin
                wait_start(10, "rot_next_start", c);
                n_vec++;
                if (c + 1 !== 2) begin
                    $display("FAIL rot_gap[%0d]: tx_done->start_tx gap=%0d, required 2", i, c + 1);
                    n_err++;
                end
            end else begin
                req = 4'b0000;
            end
        end
        step();
    endtask

    task automatic test_cts();
        int starts = 0;
        req = 4'b0100; req_data = 32'h005C_0000; cts_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_tx === 1'b1) starts++;
        end
        n_vec++;
        if (starts !== 0 || busy !== 1'b0) begin
            $display("FAIL cts_hold: starts=%0d busy=%b, required 0 0", starts, busy);
            n_err++;
        end
        cts_n = 1'b0;
        step();
        n_vec++;
        if ({gnt, start_tx, tx_data} !== {4'b0100, 1'b1, 8'h5C}) begin
            $display("FAIL cts_release: gnt=%b start=%b data=%h, required 0100 1 5c", gnt, start_tx, tx_data);
            n_err++;
        end
        req = 4'b0000; cts_n = 1'b1;
        step();
        step();
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL cts_inflight: busy=%b, required 1", busy);
            n_err++;
        end
        cts_n = 1'b0; tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int c;
        req = 4'b0001; req_data = 32'h0000_0077;
        wait_start(10, "mid_start", c);
        req = 4'b0000;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; tx_done = 1'b1;
        n_vec++;
        if ({gnt, start_tx, busy, tx_data, timeout_err, grant_id} !== {4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3}) begin
            $display("FAIL mid_reset: gnt=%b start=%b busy=%b data=%h terr=%b gid=%0d, required 0000 0 0 00 0 3",
                     gnt, start_tx, busy, tx_data, timeout_err, grant_id);
            n_err++;
        end
        step();
        tx_done = 1'b0;
        step();
        n_vec++;
        if ({gnt, start_tx, busy, grant_id} !== {4'b0000, 1'b0, 1'b0, 2'd3}) begin
            $display("FAIL mid_late_done: gnt=%b start=%b busy=%b gid=%0d, required 0000 0 0 3",
                     gnt, start_tx, busy, grant_id);
            n_err++;
        end
    endtask

    task automatic test_withdraw();
        int c;
        req = 4'b0001; req_data = 32'hD300_C1B0;
        wait_start(10, "wd_first", c);
        req = 4'b1010; req_data = 32'hD300_C1FF;
        step();
        step();
        n_vec++;
        if (tx_data !== 8'hB0) begin
            $display("FAIL wd_data_stable: tx_data=%h, required b0", tx_data);
            n_err++;
        end
        req = 4'b1000;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wait_start(10, "wd_next", c);
        n_vec++;
        if ({gnt, grant_id, tx_data} !== {4'b1000, 2'd3, 8'hD3}) begin
            $display("FAIL wd_grant: gnt=%b gid=%0d data=%h, required 1000 3 d3", gnt, grant_id, tx_data);
            n_err++;
        end
        req = 4'b0000;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL wd_immediate_done: busy=%b, required 0", busy);
            n_err++;
        end
        step();
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        int t = 0;
        do_reset();
        req = 4'b0011; req_data = 32'h0000_2221;
        wait_start(10, "to_start", c);
        req = 4'b0010;
        do begin
            step();
            t++;
        end while (timeout_err !== 1'b1 && t < 60);
        n_vec++;
        if (t !== 50 || busy !== 1'b0) begin
            $display("FAIL to_pulse: cycles=%0d busy=%b, required 50 0", t, busy);
            n_err++;
        end
        wait_start(10, "to_next", c);
        n_vec++;
        if (gnt !== 4'b0010) begin
            $display("FAIL to_next_grant: gnt=%b, required 0010", gnt);
            n_err++;
        end
        req = 4'b0000;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_cts();
        test_reset_midframe();
        test_withdraw();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
